snn_layer_sequencer: RTL and testbench

Parametrised GALS master controller for an N-layer SNN backend, generalising the fixed 3-layer dense FSM. Per-layer neuron count, weight-BRAM offset and t_min come from a runtime-loaded descriptor table. The block drives the PE-array control, the AER ack routing, and potential readout into the intermediate buffer. It computes the final-layer ArgMax sequentially, and adds an inter-layer potential clear, a watchdog timeout and sticky error reporting.

---
 rtl/snn_layer_sequencer.sv | 242 ++++++++++++++++++++++++
 tb/tb_snn_layer_sequencer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snn_layer_sequencer.sv
// Master sequencer for an N-layer SNN backend: walks a runtime-loaded layer
// descriptor table, steps the PE arrays through each layer and computes the final ArgMax.
module snn_layer_sequencer #(
  parameter int NUM_LAYERS    = 3,
  parameter int NUM_ARRAYS    = 16,
  parameter int PES_PER_ARRAY = 4,
  parameter int MAX_NEURONS   = 64,
  parameter int ADDR_W        = 10,
  parameter int TIME_W        = 8,
  parameter int ACC_W         = 32,
  parameter int TIMEOUT_W     = 16
) (
  input  logic                                 local_clk,
  input  logic                                 rst_n,
  input  logic                                 i_cfg_we,
  input  logic [2:0]                           i_cfg_layer,
  input  logic [6:0]                           i_cfg_neurons,
  input  logic [ADDR_W-1:0]                    i_cfg_offset,
  input  logic [TIME_W-1:0]                    i_cfg_tmin,
  input  logic                                 i_start,
  output logic                                 o_done,
  output logic [5:0]                           o_class,
  output logic                                 o_busy,
  output logic                                 o_error,
  output logic [1:0]                           o_err_code,
  input  logic                                 i_err_clear,
  input  logic                                 i_enc_done,
  output logic                                 o_enc_ack,
  input  logic                                 i_buf_done,
  output logic                                 o_buf_ack,
  output logic                                 o_buf_start,
  output logic [TIME_W-1:0]                    o_buf_t_max,
  output logic [6:0]                           o_buf_count,
  output logic                                 o_buf_wr_en,
  output logic [5:0]                           o_buf_wr_addr,
  output logic [ACC_W-1:0]                     o_buf_wr_data,
  output logic                                 o_src_sel,
  output logic [NUM_ARRAYS-1:0]                o_array_clk_en,
  output logic [NUM_ARRAYS*PES_PER_ARRAY-1:0]  o_pe_enable,
  output logic                                 o_reset_potential,
  output logic [ADDR_W-1:0]                    o_bram_offset,
  output logic [TIME_W-1:0]                    o_t_min,
  input  logic [NUM_ARRAYS-1:0]                i_array_ack,
  input  logic [NUM_ARRAYS-1:0]                i_array_error,
  output logic [5:0]                           o_rd_idx,
  input  logic [ACC_W-1:0]                     i_rd_potential
);

  localparam int P = NUM_ARRAYS * PES_PER_ARRAY;
  localparam logic [2:0] LAST = 3'(NUM_LAYERS - 1);

  typedef enum logic [2:0] {IDLE, CHECK, RUN, READ, CLEAR, DONE, ERROR} state_t;

  state_t                    state, state_n;
  logic [2:0]                layer, layer_n;
  logic [5:0]                rd_cnt, rd_n;
  logic [TIMEOUT_W-1:0]      wdog, wdog_n;
  logic [1:0]                code_n;
  logic [5:0]                class_n;
  logic [5:0]                best_idx, best_idx_n;
  logic signed [ACC_W-1:0]   best_val, best_val_n;
  logic                      take;

  logic [6:0]                neurons [8];
  logic [ADDR_W-1:0]         offsets [8];
  logic [TIME_W-1:0]         tmins   [8];

  logic [6:0]                cur_n, next_n, prev_n;
  logic                      desc_bad, rd_last, array_fault, ack_all;
  logic                      active_n, feed_n;

  function automatic logic [NUM_ARRAYS-1:0] array_mask(input logic [6:0] n);
    logic [NUM_ARRAYS-1:0] m;
    m = '0;
    for (int k = 0; k < NUM_ARRAYS; k++) m[k] = (k * PES_PER_ARRAY) < int'(n);
    return m;
  endfunction

  function automatic logic [P-1:0] pe_mask(input logic [6:0] n);
    logic [P-1:0] m;
    m = '0;
    for (int j = 0; j < P; j++) m[j] = j < int'(n);
    return m;
  endfunction

  always_comb begin
    desc_bad = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++)
      if (neurons[i] == 7'd0 || int'(neurons[i]) > MAX_NEURONS) desc_bad = 1'b1;
  end

  assign cur_n       = neurons[layer];
  assign next_n      = neurons[layer_n];
  assign prev_n      = neurons[layer_n - 3'd1];
  assign rd_last     = ({1'b0, rd_cnt} == cur_n - 7'd1);
  assign array_fault = (|i_array_error) && (state inside {CHECK, RUN, READ, CLEAR});
  assign active_n    = state_n inside {RUN, READ};
  assign feed_n      = (state_n == RUN) && (layer_n != 3'd0);

  // Disabled arrays count as acknowledged so they never stall the handshake.
  assign ack_all   = &(i_array_ack | ~o_array_clk_en);
  assign o_enc_ack = (state == RUN) && !o_src_sel && ack_all;
  assign o_buf_ack = (state == RUN) && o_src_sel && ack_all;

  assign o_rd_idx      = rd_cnt;
  assign o_buf_wr_addr = o_buf_wr_en ? rd_cnt : 6'd0;
  assign o_buf_wr_data = o_buf_wr_en ? i_rd_potential : '0;

  always_comb begin
    state_n    = state;
    layer_n    = layer;
    rd_n       = rd_cnt;
    wdog_n     = wdog;
    code_n     = o_err_code;
    class_n    = o_class;
    best_val_n = best_val;
    best_idx_n = best_idx;
    take       = 1'b0;
    case (state)
      IDLE:  if (i_start) state_n = CHECK;
      CHECK: begin
        if (desc_bad) begin
          state_n = ERROR;
          code_n  = 2'd3;
        end else begin
          state_n = RUN;
          layer_n = 3'd0;
          wdog_n  = '0;
        end
      end
      RUN: begin
        wdog_n = wdog + 1'b1;
        if ((layer == 3'd0) ? i_enc_done : i_buf_done) begin
          state_n = READ;
          rd_n    = 6'd0;
        end else if (&wdog_n) begin
          state_n = ERROR;
          code_n  = 2'd2;
        end
      end
      READ: begin
        // Strictly-greater update keeps the lowest index on ties.
        if (layer == LAST) begin
          take = (rd_cnt == 6'd0) || ($signed(i_rd_potential) > best_val);
          if (take) begin
            best_val_n = $signed(i_rd_potential);
            best_idx_n = rd_cnt;
          end
        end
        if (rd_last) begin
          rd_n = 6'd0;
          if (layer == LAST) begin
            state_n = DONE;
            class_n = best_idx_n;
          end else begin
            state_n = CLEAR;
          end
        end else begin
          rd_n = rd_cnt + 6'd1;
        end
      end
      CLEAR: begin
        state_n = RUN;
        layer_n = layer + 3'd1;
        wdog_n  = '0;
      end
      DONE:  if (!i_start) state_n = IDLE;
      ERROR: begin
        if (i_err_clear) begin
          state_n = IDLE;
          code_n  = 2'd0;
        end
      end
      default: state_n = IDLE;
    endcase
    if (array_fault) begin
      state_n = ERROR;
      code_n  = 2'd1;
      rd_n    = 6'd0;
    end
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      layer             <= 3'd0;
      rd_cnt            <= 6'd0;
      wdog              <= '0;
      best_val          <= '0;
      best_idx          <= 6'd0;
      for (int i = 0; i < 8; i++) begin
        neurons[i] <= '0;
        offsets[i] <= '0;
        tmins[i]   <= '0;
      end
      o_done            <= 1'b0;
      o_class           <= 6'd0;
      o_busy            <= 1'b0;
      o_error           <= 1'b0;
      o_err_code        <= 2'd0;
      o_buf_start       <= 1'b0;
      o_buf_t_max       <= '0;
      o_buf_count       <= 7'd0;
      o_buf_wr_en       <= 1'b0;
      o_src_sel         <= 1'b0;
      o_array_clk_en    <= '0;
      o_pe_enable       <= '0;
      o_reset_potential <= 1'b0;
      o_bram_offset     <= '0;
      o_t_min           <= '0;
    end else begin
      state      <= state_n;
      layer      <= layer_n;
      rd_cnt     <= rd_n;
      wdog       <= wdog_n;
      best_val   <= best_val_n;
      best_idx   <= best_idx_n;
      o_class    <= class_n;
      o_err_code <= code_n;
      if (state == IDLE && i_cfg_we && int'(i_cfg_layer) < NUM_LAYERS) begin
        neurons[i_cfg_layer] <= i_cfg_neurons;
        offsets[i_cfg_layer] <= i_cfg_offset;
        tmins[i_cfg_layer]   <= i_cfg_tmin;
      end
      o_done            <= state_n == DONE;
      o_busy            <= !(state_n inside {IDLE, DONE});
      o_error           <= state_n == ERROR;
      o_reset_potential <= state_n inside {IDLE, CLEAR};
      o_array_clk_en    <= active_n ? array_mask(next_n) : '0;
      o_pe_enable       <= active_n ? pe_mask(next_n) : '0;
      o_bram_offset     <= active_n ? offsets[layer_n] : '0;
      o_t_min           <= active_n ? tmins[layer_n] : '0;
      o_src_sel         <= feed_n;
      o_buf_start       <= feed_n;
      o_buf_t_max       <= feed_n ? tmins[layer_n] : '0;
      o_buf_count       <= feed_n ? prev_n : 7'd0;
      o_buf_wr_en       <= (state_n == READ) && (layer_n != LAST);
    end
  end

endmodule

// File: tb/tb_snn_layer_sequencer.sv
// Randomized self-checking bench for snn_layer_sequencer; expected behaviour
// comes from a layer-by-layer timeline model built from the descriptor table.
module tb_snn_layer_sequencer;

  localparam int NL    = 3;
  localparam int NA    = 16;
  localparam int PPA   = 4;
  localparam int NP    = NA * PPA;
  localparam int AW    = 10;
  localparam int TW    = 8;
  localparam int ACC_W = 32;
  localparam int TO_W  = 4;

  logic              local_clk, rst_n;
  logic              i_cfg_we;
  logic [2:0]        i_cfg_layer;
  logic [6:0]        i_cfg_neurons;
  logic [AW-1:0]     i_cfg_offset;
  logic [TW-1:0]     i_cfg_tmin;
  logic              i_start, o_done, o_busy, o_error, i_err_clear;
  logic [5:0]        o_class;
  logic [1:0]        o_err_code;
  logic              i_enc_done, o_enc_ack, i_buf_done, o_buf_ack, o_buf_start;
  logic [TW-1:0]     o_buf_t_max;
  logic [6:0]        o_buf_count;
  logic              o_buf_wr_en;
  logic [5:0]        o_buf_wr_addr;
  logic [ACC_W-1:0]  o_buf_wr_data;
  logic              o_src_sel;
  logic [NA-1:0]     o_array_clk_en;
  logic [NP-1:0]     o_pe_enable;
  logic              o_reset_potential;
  logic [AW-1:0]     o_bram_offset;
  logic [TW-1:0]     o_t_min;
  logic [NA-1:0]     i_array_ack, i_array_error;
  logic [5:0]        o_rd_idx;
  logic [ACC_W-1:0]  i_rd_potential;

  int compared = 0;
  int mismatched = 0;

  int n_l[NL];
  int off_l[NL];
  int tmin_l[NL];
  int pots[NL][64];

  snn_layer_sequencer #(.NUM_LAYERS(NL), .NUM_ARRAYS(NA), .PES_PER_ARRAY(PPA),
                        .MAX_NEURONS(64), .ADDR_W(AW), .TIME_W(TW), .ACC_W(ACC_W),
                        .TIMEOUT_W(TO_W)) dut (
    .local_clk(local_clk), .rst_n(rst_n),
    .i_cfg_we(i_cfg_we), .i_cfg_layer(i_cfg_layer), .i_cfg_neurons(i_cfg_neurons),
    .i_cfg_offset(i_cfg_offset), .i_cfg_tmin(i_cfg_tmin), .i_start(i_start),
    .o_done(o_done), .o_class(o_class), .o_busy(o_busy), .o_error(o_error),
    .o_err_code(o_err_code), .i_err_clear(i_err_clear), .i_enc_done(i_enc_done),
    .o_enc_ack(o_enc_ack), .i_buf_done(i_buf_done), .o_buf_ack(o_buf_ack),
    .o_buf_start(o_buf_start), .o_buf_t_max(o_buf_t_max), .o_buf_count(o_buf_count),
    .o_buf_wr_en(o_buf_wr_en), .o_buf_wr_addr(o_buf_wr_addr), .o_buf_wr_data(o_buf_wr_data),
    .o_src_sel(o_src_sel), .o_array_clk_en(o_array_clk_en), .o_pe_enable(o_pe_enable),
    .o_reset_potential(o_reset_potential), .o_bram_offset(o_bram_offset), .o_t_min(o_t_min),
    .i_array_ack(i_array_ack), .i_array_error(i_array_error), .o_rd_idx(o_rd_idx),
    .i_rd_potential(i_rd_potential)
  );

  initial local_clk = 1'b0;
  always #5 local_clk = ~local_clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] peExp(input int n);
    return (n >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
  endfunction

  function automatic logic [NA-1:0] arrExp(input int n);
    int a;
    a = (n + PPA - 1) / PPA;
    return NA'((1 << a) - 1);
  endfunction

  function automatic int argMax(input int l);
    int best;
    best = 0;
    for (int i = 1; i < n_l[l]; i++) if (pots[l][i] > pots[l][best]) best = i;
    return best;
  endfunction

  task automatic clearPulses();
    i_cfg_we       = 1'b0;
    i_enc_done     = 1'b0;
    i_buf_done     = 1'b0;
    i_err_clear    = 1'b0;
    i_array_error  = '0;
    i_array_ack    = '0;
    i_rd_potential = '0;
  endtask

  task automatic nextCycle();
    @(negedge local_clk);
    clearPulses();
  endtask

  task automatic setDesc(input int l, input int n, input int off, input int tmin);
    n_l[l] = n; off_l[l] = off; tmin_l[l] = tmin;
  endtask

  task automatic randomDesc();
    for (int l = 0; l < NL; l++)
      setDesc(l, $urandom_range(1, 64), $urandom_range(0, 1023), $urandom_range(0, 255));
  endtask

  task automatic loadDescriptors();
    for (int l = 0; l < NL; l++) begin
      nextCycle();
      i_cfg_we      = 1'b1;
      i_cfg_layer   = 3'(l);
      i_cfg_neurons = 7'(n_l[l]);
      i_cfg_offset  = AW'(off_l[l]);
      i_cfg_tmin    = TW'(tmin_l[l]);
      #1;
      checkOutput("idle_rstpot", o_reset_potential, 1);
    end
  endtask

  task automatic clearError();
    nextCycle();
    i_err_clear = 1'b1;
    #1;
    checkOutput("err_sticky_before_clear", o_error, 1);
    nextCycle();
    #1;
    checkOutput("err_cleared", o_error, 0);
    checkOutput("err_code_cleared", o_err_code, 0);
    checkOutput("err_idle_rstpot", o_reset_potential, 1);
  endtask

  // One full inference: descriptor load, start, every layer, DONE and return to IDLE.
  task automatic applyStimulus(input bit drop_start);
    logic [NA-1:0] am, ack;
    bit all_ack;
    int d, prev, exp_class;
    loadDescriptors();
    nextCycle();
    i_start = 1'b1;
    #1;
    checkOutput("idle_done", o_done, 0);
    nextCycle();
    #1;
    checkOutput("check_busy", o_busy, 1);
    checkOutput("check_rstpot", o_reset_potential, 0);
    for (int l = 0; l < NL; l++) begin
      am   = arrExp(n_l[l]);
      d    = $urandom_range(0, 10);
      prev = 0;
      if (l > 0) prev = n_l[l-1];
      for (int c = 0; c <= d; c++) begin
        nextCycle();
        if (drop_start && l == 0 && c == 0) i_start = 1'b0;
        if (c == d) begin
          if (l == 0) i_enc_done = 1'b1;
          else i_buf_done = 1'b1;
        end
        if (c == 0) ack = am;
        else if ($urandom_range(0, 1) == 1) ack = NA'($urandom) | am;
        else ack = NA'($urandom);
        i_array_ack = ack;
        all_ack = ((ack | ~am) == '1);
        #1;
        checkOutput("run_clk_en", o_array_clk_en, am);
        checkOutput("run_pe_en", o_pe_enable, peExp(n_l[l]));
        checkOutput("run_offset", o_bram_offset, off_l[l]);
        checkOutput("run_tmin", o_t_min, tmin_l[l]);
        checkOutput("run_src_sel", o_src_sel, l != 0);
        checkOutput("run_buf_start", o_buf_start, l != 0);
        checkOutput("run_buf_t_max", o_buf_t_max, (l != 0) ? tmin_l[l] : 0);
        checkOutput("run_buf_count", o_buf_count, prev);
        checkOutput("run_enc_ack", o_enc_ack, (l == 0) && all_ack);
        checkOutput("run_buf_ack", o_buf_ack, (l != 0) && all_ack);
        checkOutput("run_busy", o_busy, 1);
        checkOutput("run_wr_en", o_buf_wr_en, 0);
      end
      for (int i = 0; i < n_l[l]; i++) begin
        nextCycle();
        i_rd_potential = 32'(pots[l][i]);
        i_array_ack    = NA'($urandom);
        #1;
        checkOutput("read_idx", o_rd_idx, i);
        checkOutput("read_wr_en", o_buf_wr_en, l < NL - 1);
        checkOutput("read_wr_addr", o_buf_wr_addr, (l < NL - 1) ? i : 0);
        checkOutput("read_wr_data", o_buf_wr_data, (l < NL - 1) ? 32'(pots[l][i]) : 32'd0);
        checkOutput("read_clk_en", o_array_clk_en, am);
        checkOutput("read_acks", {o_enc_ack, o_buf_ack}, 0);
      end
      if (l < NL - 1) begin
        nextCycle();
        #1;
        checkOutput("clear_rstpot", o_reset_potential, 1);
        checkOutput("clear_clk_en", o_array_clk_en, 0);
        checkOutput("clear_wr_en", o_buf_wr_en, 0);
        checkOutput("clear_busy", o_busy, 1);
      end
    end
    exp_class = argMax(NL - 1);
    nextCycle();
    #1;
    checkOutput("done_flag", o_done, 1);
    checkOutput("done_class", o_class, exp_class);
    checkOutput("done_busy", o_busy, 0);
    if (!drop_start) begin
      repeat ($urandom_range(1, 3)) begin
        nextCycle();
        #1;
        checkOutput("done_held", o_done, 1);
      end
      nextCycle();
      i_start = 1'b0;
      #1;
      checkOutput("done_last_cycle", o_done, 1);
    end
    nextCycle();
    #1;
    checkOutput("idle_done_low", o_done, 0);
    checkOutput("idle_class_kept", o_class, exp_class);
    checkOutput("idle_rstpot_back", o_reset_potential, 1);
  endtask

  task automatic timeoutTest();
    randomDesc();
    loadDescriptors();
    nextCycle();
    i_start = 1'b1;
    nextCycle();
    i_start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      nextCycle();
      i_array_ack = NA'($urandom);
      #1;
      checkOutput("to_run_no_error", o_error, 0);
      checkOutput("to_run_clk_en", o_array_clk_en, arrExp(n_l[0]));
    end
    nextCycle();
    #1;
    checkOutput("to_error", o_error, 1);
    checkOutput("to_code", o_err_code, 2);
    checkOutput("to_clk_en_off", o_array_clk_en, 0);
    checkOutput("to_busy", o_busy, 1);
    nextCycle();
    #1;
    checkOutput("to_sticky", o_error, 1);
    clearError();
  endtask

  task automatic arrayErrorTest();
    int e;
    randomDesc();
    n_l[0] = $urandom_range(4, 64);
    loadDescriptors();
    nextCycle();
    i_start = 1'b1;
    nextCycle();
    i_start = 1'b0;
    nextCycle();
    i_enc_done  = 1'b1;
    i_array_ack = '1;
    e = $urandom_range(1, n_l[0] - 2);
    for (int i = 0; i <= e; i++) begin
      nextCycle();
      i_rd_potential = 32'($urandom);
      if (i == e) i_array_error = 16'h0008;
      #1;
      checkOutput("ae_wr_en", o_buf_wr_en, 1);
      checkOutput("ae_wr_addr", o_buf_wr_addr, i);
    end
    nextCycle();
    #1;
    checkOutput("ae_error", o_error, 1);
    checkOutput("ae_code", o_err_code, 1);
    checkOutput("ae_clk_en_off", o_array_clk_en, 0);
    repeat (3) begin
      nextCycle();
      #1;
      checkOutput("ae_no_writes", o_buf_wr_en, 0);
    end
    clearError();
  endtask

  task automatic badDescTest();
    randomDesc();
    n_l[1] = ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(65, 127);
    loadDescriptors();
    for (int attempt = 0; attempt < 2; attempt++) begin
      nextCycle();
      i_start = 1'b1;
      nextCycle();
      i_start       = 1'b0;
      i_cfg_we      = 1'b1;
      i_cfg_layer   = 3'd1;
      i_cfg_neurons = 7'd10;
      #1;
      checkOutput("bd_check_busy", o_busy, 1);
      nextCycle();
      #1;
      checkOutput("bd_error", o_error, 1);
      checkOutput("bd_code", o_err_code, 3);
      clearError();
    end
  endtask

  task automatic midResetTest();
    randomDesc();
    loadDescriptors();
    nextCycle();
    i_start = 1'b1;
    nextCycle();
    i_start = 1'b0;
    nextCycle();
    #1;
    checkOutput("mr_running", o_busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mr_busy", o_busy, 0);
    checkOutput("mr_clk_en", o_array_clk_en, 0);
    checkOutput("mr_rstpot", o_reset_potential, 0);
    nextCycle();
    rst_n = 1'b1;
    nextCycle();
    #1;
    checkOutput("mr_idle", o_reset_potential, 1);
    nextCycle();
    i_start = 1'b1;
    nextCycle();
    i_start = 1'b0;
    nextCycle();
    #1;
    checkOutput("mr_desc_lost", o_err_code, 3);
    clearError();
  endtask

  initial begin
    rst_n         = 1'b0;
    i_start       = 1'b0;
    i_cfg_layer   = '0;
    i_cfg_neurons = '0;
    i_cfg_offset  = '0;
    i_cfg_tmin    = '0;
    clearPulses();
    #3;
    checkOutput("rst_done", o_done, 0);
    checkOutput("rst_busy", o_busy, 0);
    checkOutput("rst_error", {o_error, o_err_code}, 0);
    checkOutput("rst_class", o_class, 0);
    checkOutput("rst_rstpot", o_reset_potential, 0);
    checkOutput("rst_enables", {o_array_clk_en, o_pe_enable}, 0);
    checkOutput("rst_wr_en", o_buf_wr_en, 0);
    repeat (2) @(negedge local_clk);
    rst_n = 1'b1;

    setDesc(0, 64, 0, 0);
    setDesc(1, 32, 160, 20);
    setDesc(2, 3, 224, 40);
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < 64; i++) pots[l][i] = i * i - 5;
    applyStimulus(1'b0);

    randomDesc();
    n_l[0] = 5;
    n_l[2] = 3;
    for (int l = 0; l < NL; l++)
      for (int i = 0; i < 64; i++) pots[l][i] = int'($urandom);
    pots[2][0] = 7; pots[2][1] = 7; pots[2][2] = -3;
    applyStimulus(1'b1);

    for (int r = 0; r < 5; r++) begin
      randomDesc();
      for (int l = 0; l < NL - 1; l++)
        for (int i = 0; i < 64; i++) pots[l][i] = int'($urandom);
      for (int i = 0; i < 64; i++) pots[NL-1][i] = int'($urandom_range(0, 6)) - 3;
      applyStimulus(r[0]);
    end

    timeoutTest();
    arrayErrorTest();
    badDescTest();
    midResetTest();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
